// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if: byte-source and transmitter bus around the shared UART arbiter.
interface uart_tx_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
);
    logic [NUM_REQ-1:0]   req_valid;
    logic [8*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]   req_last;
    logic [NUM_REQ-1:0]   req_ready;
    logic                 tx_start;
    logic [7:0]           tx_data;
    logic                 tx_busy;
    logic                 tx_done;
    logic [ID_W-1:0]      grant_id;
    logic                 active;
    logic                 timeout_err;
    modport master (
        output req_valid, req_data, req_last, tx_busy, tx_done,
        input  req_ready, tx_start, tx_data, grant_id, active, timeout_err
    );
    modport slave (
        input  req_valid, req_data, req_last, tx_busy, tx_done,
        output req_ready, tx_start, tx_data, grant_id, active, timeout_err
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin, frame-locked sharing of one UART transmitter with a watchdog.
module uart_tx_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2,
    parameter int TIMEOUT = 2047
) (
    input logic clk,
    input logic rst,
    uart_tx_arbiter_if.slave bus
);
    localparam int VW   = 1 << ID_W;
    localparam int DW   = 8 * VW;
    localparam int WD_W = $clog2(TIMEOUT + 1);
    typedef enum logic [1:0] {IDLE, LOAD, START, WAIT} state_t;
    state_t          state;
    logic [ID_W-1:0] rr_ptr, winner;
    logic [WD_W-1:0] wdog;
    logic [VW-1:0]   vpad, lpad;
    logic [DW-1:0]   dpad;
    logic            lock, last_q, found, abort, hs;
    int              s;
    // Pad the per-source vectors to a power of two so grant_id indexes them exactly.
    assign vpad = VW'(bus.req_valid);
    assign lpad = VW'(bus.req_last);
    assign dpad = DW'(bus.req_data);
    always_comb begin
        winner = '0;
        found  = 1'b0;
        s      = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            s = int'(rr_ptr) + k;
            s = (s >= NUM_REQ) ? s - NUM_REQ : s;
            if (!found && vpad[ID_W'(s)]) begin
                winner = ID_W'(s);
                found  = 1'b1;
            end
        end
    end
    assign abort = (state == WAIT || (state == LOAD && lock)) && wdog == WD_W'(TIMEOUT - 1);
    assign hs    = state == LOAD && vpad[bus.grant_id] && !abort;
    assign bus.req_ready = (state == LOAD && !abort) ? NUM_REQ'(vpad & (VW'(1) << bus.grant_id)) : '0;
    assign bus.active    = state != IDLE;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= IDLE;
            rr_ptr          <= ID_W'(NUM_REQ - 1);
            lock            <= 1'b0;
            last_q          <= 1'b0;
            wdog            <= '0;
            bus.grant_id    <= '0;
            bus.tx_data     <= '0;
            bus.tx_start    <= 1'b0;
            bus.timeout_err <= 1'b0;
        end else begin
            bus.tx_start    <= 1'b0;
            bus.timeout_err <= 1'b0;
            if (state == WAIT || (state == LOAD && lock))
                wdog <= wdog + 1'b1;
            if (abort) begin
                state           <= IDLE;
                lock            <= 1'b0;
                rr_ptr          <= bus.grant_id;
                wdog            <= '0;
                bus.timeout_err <= 1'b1;
            end else begin
                case (state)
                    IDLE: if (found && !bus.tx_busy) begin
                        bus.grant_id <= winner;
                        state        <= LOAD;
                    end
                    LOAD: if (hs) begin
                        bus.tx_data  <= dpad[{bus.grant_id, 3'b000} +: 8];
                        last_q       <= lpad[bus.grant_id];
                        bus.tx_start <= 1'b1;
                        state        <= START;
                    end else if (!lock) begin
                        state <= IDLE;
                    end
                    START: begin
                        wdog  <= '0;
                        state <= WAIT;
                    end
                    WAIT: if (bus.tx_done) begin
                        lock  <= !last_q;
                        state <= last_q ? IDLE : LOAD;
                        if (last_q)
                            rr_ptr <= bus.grant_id;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed checks of arbitration order, frame lock, watchdog and reset.
module tb_uart_tx_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad = 0;
    always #5 clk = ~clk;
    uart_tx_arbiter_if #(.NUM_REQ(4), .ID_W(2)) bus ();
    uart_tx_arbiter #(.NUM_REQ(4), .ID_W(2), .TIMEOUT(15)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );
    task automatic tick();
        @(negedge clk);
    endtask
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask
    // Full single-byte transaction, entered at an IDLE negedge with source id valid.
    task automatic serve(input int id, input logic [7:0] d);
        tick();
        chk("serve_grant", 32'(bus.grant_id), id);
        chk("serve_ready", 32'(bus.req_ready), 32'(1) << id);
        tick();
        chk("serve_start", 32'(bus.tx_start), 1);
        chk("serve_data", 32'(bus.tx_data), 32'(d));
        bus.req_valid[id] = 1'b0;
        tick();
        chk("serve_wait", {30'd0, bus.active, bus.tx_start}, 2);
        bus.tx_done = 1'b1;
        tick();
        bus.tx_done = 1'b0;
        chk("serve_idle", 32'(bus.active), 0);
    endtask
    initial begin
        bus.req_valid = '0;
        bus.req_data  = '0;
        bus.req_last  = '0;
        bus.tx_busy   = 1'b0;
        bus.tx_done   = 1'b0;
        tick();
        tick();
        chk("rst_active", 32'(bus.active), 0);
        chk("rst_grant", 32'(bus.grant_id), 0);
        chk("rst_ready", 32'(bus.req_ready), 0);
        chk("rst_start", 32'(bus.tx_start), 0);
        chk("rst_data", 32'(bus.tx_data), 0);
        chk("rst_terr", 32'(bus.timeout_err), 0);
        rst = 1'b0;
        // reset while in WAIT
        bus.req_valid = 4'b0010;
        bus.req_data[15:8] = 8'h5A;
        bus.req_last = 4'b1111;
        tick();
        chk("t1_grant", 32'(bus.grant_id), 1);
        tick();
        chk("t1_data", 32'(bus.tx_data), 32'h5A);
        bus.req_valid = '0;
        tick();
        chk("t1_inwait", 32'(bus.active), 1);
        rst = 1'b1;
        #1;
        chk("t1_rst_active", 32'(bus.active), 0);
        chk("t1_rst_grant", 32'(bus.grant_id), 0);
        chk("t1_rst_data", 32'(bus.tx_data), 0);
        chk("t1_rst_ready", 32'(bus.req_ready), 0);
        tick();
        rst = 1'b0;
        bus.req_valid[2] = 1'b1;
        bus.req_data[23:16] = 8'hA5;
        serve(2, 8'hA5);
        // round-robin over all four, then rr pointer after src1
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.req_valid = 4'b1111;
        bus.req_data = 32'hC3C2C1C0;
        serve(0, 8'hC0);
        serve(1, 8'hC1);
        serve(2, 8'hC2);
        serve(3, 8'hC3);
        bus.req_valid = 4'b0010;
        serve(1, 8'hC1);
        bus.req_valid = 4'b1001;
        serve(3, 8'hC3);
        serve(0, 8'hC0);
        // locked three-byte frame from src1 with src0 waiting
        bus.req_valid = 4'b0011;
        bus.req_data[7:0] = 8'h0F;
        bus.req_data[15:8] = 8'h11;
        bus.req_last = 4'b0001;
        tick();
        chk("t3_grant", 32'(bus.grant_id), 1);
        chk("t3_ready1", 32'(bus.req_ready), 32'b0010);
        tick();
        chk("t3_b1", 32'(bus.tx_data), 32'h11);
        bus.req_data[15:8] = 8'h22;
        tick();
        chk("t3_w1_ready", 32'(bus.req_ready), 0);
        bus.tx_done = 1'b1;
        tick();
        bus.tx_done = 1'b0;
        chk("t3_ready2", 32'(bus.req_ready), 32'b0010);
        tick();
        chk("t3_start2", 32'(bus.tx_start), 1);
        chk("t3_b2", 32'(bus.tx_data), 32'h22);
        bus.req_data[15:8] = 8'h33;
        bus.req_last[1] = 1'b1;
        tick();
        chk("t3_w2_ready", 32'(bus.req_ready), 0);
        bus.tx_done = 1'b1;
        tick();
        bus.tx_done = 1'b0;
        chk("t3_ready3", 32'(bus.req_ready), 32'b0010);
        tick();
        chk("t3_b3", 32'(bus.tx_data), 32'h33);
        bus.req_valid[1] = 1'b0;
        tick();
        chk("t3_w3_ready", 32'(bus.req_ready), 0);
        bus.tx_done = 1'b1;
        tick();
        bus.tx_done = 1'b0;
        chk("t3_idle", 32'(bus.active), 0);
        serve(0, 8'h0F);
        // owner idles inside a locked frame until the watchdog fires
        bus.req_valid = 4'b1100;
        bus.req_data[23:16] = 8'h44;
        bus.req_data[31:24] = 8'h55;
        bus.req_last = 4'b1000;
        tick();
        chk("t4_grant", 32'(bus.grant_id), 2);
        tick();
        chk("t4_data", 32'(bus.tx_data), 32'h44);
        bus.req_valid[2] = 1'b0;
        tick();
        bus.tx_done = 1'b1;
        tick();
        bus.tx_done = 1'b0;
        for (int i = 0; i < 6; i++) begin
            chk("t4_hold_ready", 32'(bus.req_ready), 0);
            chk("t4_hold_grant", 32'(bus.grant_id), 2);
            chk("t4_hold_active", 32'(bus.active), 1);
            tick();
        end
        for (int i = 0; i < 7; i++) begin
            chk("t4_hold_terr", 32'(bus.timeout_err), 0);
            tick();
        end
        bus.req_valid[2] = 1'b1;
        bus.req_data[23:16] = 8'h66;
        #1;
        chk("t4_abort_ready", 32'(bus.req_ready), 0);
        chk("t4_abort_terr", 32'(bus.timeout_err), 0);
        tick();
        chk("t4_terr", 32'(bus.timeout_err), 1);
        chk("t4_terr_idle", 32'(bus.active), 0);
        chk("t4_no_start", 32'(bus.tx_start), 0);
        bus.req_valid[2] = 1'b0;
        serve(3, 8'h55);
        // transmitter never reports done
        bus.req_valid = 4'b0011;
        bus.req_data[7:0] = 8'h77;
        bus.req_data[15:8] = 8'h88;
        bus.req_last = 4'b0011;
        tick();
        chk("t5_grant", 32'(bus.grant_id), 0);
        tick();
        chk("t5_start", 32'(bus.tx_start), 1);
        bus.req_valid[0] = 1'b0;
        for (int i = 0; i < 15; i++) begin
            tick();
            chk("t5_wait_terr", 32'(bus.timeout_err), 0);
            chk("t5_wait_active", 32'(bus.active), 1);
        end
        tick();
        chk("t5_terr", 32'(bus.timeout_err), 1);
        chk("t5_idle", 32'(bus.active), 0);
        serve(1, 8'h88);
        chk("t5_terr_once", 32'(bus.timeout_err), 0);
        // tx_busy blocks grants; stray tx_done in IDLE is ignored
        bus.tx_busy = 1'b1;
        bus.tx_done = 1'b1;
        bus.req_valid[1] = 1'b1;
        bus.req_data[15:8] = 8'h99;
        tick();
        bus.tx_done = 1'b0;
        chk("t6_busy_active", 32'(bus.active), 0);
        chk("t6_busy_ready", 32'(bus.req_ready), 0);
        tick();
        chk("t6_busy_active2", 32'(bus.active), 0);
        bus.tx_busy = 1'b0;
        serve(1, 8'h99);
        bus.req_valid[1] = 1'b1;
        bus.req_data[15:8] = 8'hAA;
        serve(1, 8'hAA);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
